door_code_writer: RTL

//  Programs the passcode that the door lock checker compares against.

---
 rtl/door_code_writer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/door_code_writer.sv
// Passcode enrolment for the door lock: the new code is keyed in twice while unlocked and
// committed to code_out only when both entries agree; any abort keeps the previous code.
module door_code_writer #(
    parameter int unsigned           CODE_LEN     = 4,
    parameter int unsigned           TIME_OUT     = 10,
    parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE = 8'hD8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            btn,
    input  logic                  unlocked,
    input  logic                  prog_req,
    output logic [2*CODE_LEN-1:0] code_out,
    output logic                  prog_busy,
    output logic                  prog_ok,
    output logic                  prog_fail
);

    localparam int unsigned CW = $clog2(CODE_LEN + 1);
    localparam int unsigned TW = $clog2(TIME_OUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StEnter1,
        StEnter2,
        StCommit,
        StFail
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [TW-1:0]         timer;
    logic [2*CODE_LEN-1:0] shadow;
    logic                  mismatch;

    logic          press_valid;
    logic          press_illegal;
    logic [1:0]    digit;
    logic [TW-1:0] timer_inc;
    logic          timeout;
    logic          abort;
    logic          last_digit;
    logic          digit_neq;

    always_comb begin
        digit = 2'd0;
        unique case (btn)
            4'b0001: digit = 2'd0;
            4'b0010: digit = 2'd1;
            4'b0100: digit = 2'd2;
            4'b1000: digit = 2'd3;
            default: digit = 2'd0;
        endcase
    end

    assign press_valid   = $onehot(btn);
    assign press_illegal = (btn != 4'd0) && !press_valid;
    assign timer_inc     = (timer == TW'(TIME_OUT)) ? timer : timer + TW'(1);
    // Abort on the edge where the idle count would reach TIME_OUT.
    assign timeout       = (btn == 4'd0) && (timer_inc == TW'(TIME_OUT));
    assign abort         = press_illegal || timeout || !unlocked;
    assign last_digit    = (cnt == CW'(CODE_LEN - 1));
    assign digit_neq     = (digit != shadow[2*int'(cnt) +: 2]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= '0;
            timer     <= '0;
            shadow    <= '0;
            mismatch  <= 1'b0;
            code_out  <= DEFAULT_CODE;
            prog_busy <= 1'b0;
            prog_ok   <= 1'b0;
            prog_fail <= 1'b0;
        end else begin
            prog_ok   <= 1'b0;
            prog_fail <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (prog_req && unlocked) begin
                        state     <= StEnter1;
                        cnt       <= '0;
                        timer     <= '0;
                        mismatch  <= 1'b0;
                        prog_busy <= 1'b1;
                    end
                end
                StEnter1, StEnter2: begin
                    if (abort) begin
                        state     <= StFail;
                        timer     <= '0;
                        prog_fail <= 1'b1;
                    end else if (press_valid) begin
                        timer <= '0;
                        if (state == StEnter1) begin
                            shadow[2*int'(cnt) +: 2] <= digit;
                            if (last_digit) begin
                                state <= StEnter2;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (last_digit) begin
                            cnt <= '0;
                            if (mismatch || digit_neq) begin
                                state     <= StFail;
                                prog_fail <= 1'b1;
                            end else begin
                                state   <= StCommit;
                                prog_ok <= 1'b1;
                            end
                        end else begin
                            mismatch <= mismatch | digit_neq;
                            cnt      <= cnt + CW'(1);
                        end
                    end else begin
                        timer <= timer_inc;
                    end
                end
                StCommit: begin
                    code_out  <= shadow;
                    state     <= StIdle;
                    prog_busy <= 1'b0;
                end
                StFail: begin
                    shadow    <= '0;
                    cnt       <= '0;
                    mismatch  <= 1'b0;
                    state     <= StIdle;
                    prog_busy <= 1'b0;
                end
                default: begin
                    state     <= StIdle;
                    prog_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
